alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Alarm state controller clocked at CLK100MHZ, driven by the single-cycle 1 Hz/100 Hz tick strobes from the time base.
//  Compares current time against the alarm setting and sequences the alarm through ring, snooze and timeout.
//  Drives the buzzer with a beep pattern derived from tick_100hz.
//  Sits between the time base/timekeeping counters and the buzzer/LED/display outputs.
// PARAMETERS
//  RING_TIMEOUT_SEC  60   seconds of ringing before auto-stop to IDLE (1..1023)
//  SNOOZE_SEC        300  snooze length in seconds (1..1023)
//  MAX_SNOOZE        3    snoozes allowed per alarm event (0..7)
//  BEEP_TICKS        25   tick_100hz strobes per beep half-period (1..255)
// PORTS
//  CLK100MHZ    in   1   system clock, single clock domain
//  rst          in   1   synchronous, active-high reset
//  tick_1hz     in   1   one-cycle strobe, once per second
//  tick_100hz   in   1   one-cycle strobe, 100 per second
//  time_h       in   5   current hour, 0..23
//  time_m       in   6   current minute, 0..59
//  time_s       in   6   current second, 0..59
//  alarm_h      in   5   alarm hour, 0..23
//  alarm_m      in   6   alarm minute, 0..59
//  alarm_en     in   1   alarm armed (level)
//  snooze       in   1   one-cycle debounced snooze request
//  stop         in   1   one-cycle debounced stop request
//  state        out  2   00 IDLE, 01 RING, 10 SNOOZE (11 unused)
//  ringing      out  1   high while state==RING
//  buzzer       out  1   beep output, RING only
//  snooze_left  out  10  seconds remaining in SNOOZE, else 0
//  snooze_count out  3   snoozes used in current alarm event
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Internal match_q, ring_cnt, beep_cnt and beep_phase are cleared.
//  match = alarm_en & time_h==alarm_h & time_m==alarm_m & time_s==0 (combinational).
//  match_q <= match each cycle; match_rise = match & ~match_q.
//  Priority per cycle: rst > ~alarm_en > stop > snooze > tick-driven transitions.
//  ~alarm_en in any state -> IDLE next edge. snooze_left and snooze_count clear.
//  IDLE: match_rise -> RING. ring_cnt=RING_TIMEOUT_SEC, beep_phase=1, beep_cnt=0, snooze_count=0.
//    ringing and buzzer go high on the edge after the first cycle match is true (1-cycle latency).
//  RING: stop -> IDLE.
//    snooze & snooze_count<MAX_SNOOZE -> SNOOZE, snooze_left=SNOOZE_SEC, snooze_count+1.
//    snooze with snooze_count==MAX_SNOOZE is ignored; the alarm stays in RING.
//    tick_1hz: ring_cnt-1. A tick with ring_cnt==1 -> IDLE (timeout).
//    Snooze and timeout tick in the same cycle -> SNOOZE wins.
//  SNOOZE: stop -> IDLE. snooze is ignored.
//    tick_1hz: snooze_left-1. A tick with snooze_left==1 -> RING, with ring_cnt, beep_phase and beep_cnt reloaded as on entry.
//  Entering IDLE by any path: snooze_left=0. snooze_count holds until the next RING entry from IDLE or until ~alarm_en.
//  Retrigger: match stays true for all of second 0, but only match_rise fires.
//    A stop or timeout inside the match second does not re-ring.
//    match_rise while in RING or SNOOZE is ignored.
//  Beep: in RING, each tick_100hz increments beep_cnt. At beep_cnt==BEEP_TICKS-1 on a tick, beep_cnt=0 and beep_phase toggles.
//    buzzer = (state==RING) & beep_phase, registered.
//    buzzer is 0 in IDLE/SNOOZE; beep_cnt is held at 0 outside RING.
//  Counter widths: ring_cnt and snooze_left are 10 bits and never wrap. Decrement happens only when the value is >=1.
//  Simultaneous tick_1hz and tick_100hz are both honoured in the same cycle.
//  A synchronous rst mid-ring or mid-snooze returns everything to reset values on that edge; the buzzer drops the same edge.
// TESTING (RING_TIMEOUT_SEC=3, SNOOZE_SEC=5, MAX_SNOOZE=1, BEEP_TICKS=2)
//  1. alarm 07:30, time steps to 07:30:00, alarm_en=1 -> state=01, ringing=1, buzzer=1 one cycle later.
//     buzzer toggles every 2 tick_100hz strobes.
//  2. In RING, 3 tick_1hz with no input -> state=00 after the 3rd tick.
//     Time held at 07:30:00 further -> no re-ring.
//  3. RING, pulse snooze -> state=10, snooze_left=5, snooze_count=1. After 5 ticks -> state=01.
//     A second snooze is ignored (still 01).
//  4. RING, assert snooze and stop in the same cycle -> state=00, snooze_left=0.
//     Snooze pulse on the same cycle as the timeout tick -> state=10.
//  5. SNOOZE with snooze_left=3, drop alarm_en -> state=00, snooze_count=0, buzzer=0 next edge.
//  6. rst pulse mid-RING -> all outputs 0 on that edge.
//     With rst held, a match condition does not ring; after release, a fresh match_rise rings.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the time base / timekeeping side and the alarm
// sequencer. The master side supplies time, ticks and user requests;
// the slave side (the sequencer) returns alarm state and buzzer drive.
interface alarm_sequencer_if;
    logic       tick_1hz;
    logic       tick_100hz;
    logic [4:0] time_h;
    logic [5:0] time_m;
    logic [5:0] time_s;
    logic [4:0] alarm_h;
    logic [5:0] alarm_m;
    logic       alarm_en;
    logic       snooze;
    logic       stop;
    logic [1:0] state;
    logic       ringing;
    logic       buzzer;
    logic [9:0] snooze_left;
    logic [2:0] snooze_count;

    modport master (
        output tick_1hz, tick_100hz, time_h, time_m, time_s,
               alarm_h, alarm_m, alarm_en, snooze, stop,
        input  state, ringing, buzzer, snooze_left, snooze_count
    );

    modport slave (
        input  tick_1hz, tick_100hz, time_h, time_m, time_s,
               alarm_h, alarm_m, alarm_en, snooze, stop,
        output state, ringing, buzzer, snooze_left, snooze_count
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm state controller: detects the alarm time, sequences the alarm
// through IDLE / RING / SNOOZE with a ring timeout and a bounded number of
// snoozes, and produces a registered beep pattern from the 100 Hz tick.
module alarm_sequencer #(
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int SNOOZE_SEC       = 300,
    parameter int MAX_SNOOZE       = 3,
    parameter int BEEP_TICKS       = 25
) (
    input  logic           CLK100MHZ,
    input  logic           rst,
    alarm_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RING   = 2'b01,
        ST_SNOOZE = 2'b10
    } state_t;

    localparam logic [9:0] RING_LOAD   = 10'(RING_TIMEOUT_SEC);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);
    localparam logic [7:0] BEEP_LAST   = 8'(BEEP_TICKS - 1);

    state_t     state_q, state_d;
    logic       match_q;
    logic [9:0] ring_cnt_q, ring_cnt_d;
    logic [9:0] snooze_left_q, snooze_left_d;
    logic [2:0] snooze_count_q, snooze_count_d;
    logic [7:0] beep_cnt_q, beep_cnt_d;
    logic       beep_phase_q, beep_phase_d;
    logic       buzzer_q, buzzer_d;

    logic       match;
    logic       match_rise;

    // Alarm time match; only its rising edge may start a ring, so holding
    // the time inside second 0 after a stop or timeout never re-rings.
    assign match = bus.alarm_en && (bus.time_h == bus.alarm_h) &&
                   (bus.time_m == bus.alarm_m) && (bus.time_s == 6'd0);
    assign match_rise = match && !match_q;

    // Next-state and counter update, priority: ~alarm_en > stop > snooze > ticks.
    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snooze_left_d  = snooze_left_q;
        snooze_count_d = snooze_count_q;
        beep_cnt_d     = beep_cnt_q;
        beep_phase_d   = beep_phase_q;

        if (!bus.alarm_en) begin
            state_d        = ST_IDLE;
            snooze_left_d  = 10'd0;
            snooze_count_d = 3'd0;
            beep_cnt_d     = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match_rise) begin
                        state_d        = ST_RING;
                        ring_cnt_d     = RING_LOAD;
                        beep_phase_d   = 1'b1;
                        beep_cnt_d     = 8'd0;
                        snooze_count_d = 3'd0;
                    end
                end
                ST_RING: begin
                    if (bus.stop) begin
                        state_d       = ST_IDLE;
                        snooze_left_d = 10'd0;
                        beep_cnt_d    = 8'd0;
                    end else if (bus.snooze && (snooze_count_q < SNOOZE_MAX)) begin
                        // Snooze beats a timeout tick landing in the same cycle.
                        state_d        = ST_SNOOZE;
                        snooze_left_d  = SNOOZE_LOAD;
                        snooze_count_d = snooze_count_q + 3'd1;
                        beep_cnt_d     = 8'd0;
                    end else begin
                        if (bus.tick_1hz && (ring_cnt_q >= 10'd1)) begin
                            if (ring_cnt_q == 10'd1) begin
                                state_d       = ST_IDLE;
                                snooze_left_d = 10'd0;
                            end
                            ring_cnt_d = ring_cnt_q - 10'd1;
                        end
                        if (state_d != ST_RING) begin
                            beep_cnt_d = 8'd0;
                        end else if (bus.tick_100hz) begin
                            if (beep_cnt_q == BEEP_LAST) begin
                                beep_cnt_d   = 8'd0;
                                beep_phase_d = !beep_phase_q;
                            end else begin
                                beep_cnt_d = beep_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (bus.stop) begin
                        state_d       = ST_IDLE;
                        snooze_left_d = 10'd0;
                    end else if (bus.tick_1hz && (snooze_left_q >= 10'd1)) begin
                        if (snooze_left_q == 10'd1) begin
                            state_d       = ST_RING;
                            snooze_left_d = 10'd0;
                            ring_cnt_d    = RING_LOAD;
                            beep_phase_d  = 1'b1;
                            beep_cnt_d    = 8'd0;
                        end else begin
                            snooze_left_d = snooze_left_q - 10'd1;
                        end
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    snooze_left_d = 10'd0;
                    beep_cnt_d    = 8'd0;
                end
            endcase
        end

        // Buzzer follows the next state so it rises and drops with ringing.
        buzzer_d = (state_d == ST_RING) && beep_phase_d;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            match_q        <= 1'b0;
            ring_cnt_q     <= 10'd0;
            snooze_left_q  <= 10'd0;
            snooze_count_q <= 3'd0;
            beep_cnt_q     <= 8'd0;
            beep_phase_q   <= 1'b0;
            buzzer_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            match_q        <= match;
            ring_cnt_q     <= ring_cnt_d;
            snooze_left_q  <= snooze_left_d;
            snooze_count_q <= snooze_count_d;
            beep_cnt_q     <= beep_cnt_d;
            beep_phase_q   <= beep_phase_d;
            buzzer_q       <= buzzer_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.ringing      = (state_q == ST_RING);
    assign bus.buzzer       = buzzer_q;
    assign bus.snooze_left  = snooze_left_q;
    assign bus.snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer with short timing parameters: a vector table
// for ring/beep/timeout/snooze flows, then hand-written sequences for
// simultaneous requests, alarm disable and reset.
module tb_alarm_sequencer;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [5:0] min;
        logic [5:0] sec;
        logic       t1;
        logic       t100;
        logic       sn;
        logic       sp;
    } in_t;

    typedef struct packed {
        logic [1:0] st;
        logic       ring;
        logic       bz;
        logic [9:0] sl;
        logic [2:0] sc;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nfail;
    int   id;
    vec_t tbl[$];
    exp_t sb[$];

    alarm_sequencer_if bus();

    alarm_sequencer #(
        .RING_TIMEOUT_SEC(3),
        .SNOOZE_SEC(5),
        .MAX_SNOOZE(1),
        .BEEP_TICKS(2)
    ) dut (
        .CLK100MHZ(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", nvec);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input bit r, input bit en, input int m, input int s,
                                input bit t1, input bit t100, input bit sn, input bit sp,
                                input int st, input int bz, input int sl, input int sc);
        vec_t v;
        v.i.rst  = r;
        v.i.en   = en;
        v.i.min  = 6'(m);
        v.i.sec  = 6'(s);
        v.i.t1   = t1;
        v.i.t100 = t100;
        v.i.sn   = sn;
        v.i.sp   = sp;
        v.e.st   = 2'(st);
        v.e.ring = (st == 1);
        v.e.bz   = 1'(bz);
        v.e.sl   = 10'(sl);
        v.e.sc   = 3'(sc);
        return v;
    endfunction

    task automatic add(input bit r, input bit en, input int m, input int s,
                       input bit t1, input bit t100, input bit sn, input bit sp,
                       input int st, input int bz, input int sl, input int sc);
        tbl.push_back(mk(r, en, m, s, t1, t100, sn, sp, st, bz, sl, sc));
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        rst             = v.i.rst;
        bus.alarm_en    = v.i.en;
        bus.time_m      = v.i.min;
        bus.time_s      = v.i.sec;
        bus.tick_1hz    = v.i.t1;
        bus.tick_100hz  = v.i.t100;
        bus.snooze      = v.i.sn;
        bus.stop        = v.i.sp;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = {bus.state, bus.ringing, bus.buzzer, bus.snooze_left, bus.snooze_count};
        nvec++;
        if (got !== e) begin
            nfail++;
            $display("FAIL vec%0d: got st=%b ring=%b bz=%b sl=%0d sc=%0d, want st=%b ring=%b bz=%b sl=%0d sc=%0d",
                     id, got.st, got.ring, got.bz, got.sl, got.sc, e.st, e.ring, e.bz, e.sl, e.sc);
        end
        id++;
        @(negedge clk);
    endtask

    task automatic run(input bit r, input bit en, input int m, input int s,
                       input bit t1, input bit t100, input bit sn, input bit sp,
                       input int st, input int bz, input int sl, input int sc);
        step(mk(r, en, m, s, t1, t100, sn, sp, st, bz, sl, sc));
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        id    = 0;
        rst   = 1'b1;
        bus.tick_1hz   = 1'b0;
        bus.tick_100hz = 1'b0;
        bus.time_h     = 5'd7;
        bus.time_m     = 6'd29;
        bus.time_s     = 6'd59;
        bus.alarm_h    = 5'd7;
        bus.alarm_m    = 6'd30;
        bus.alarm_en   = 1'b1;
        bus.snooze     = 1'b0;
        bus.stop       = 1'b0;

        //   rst en  m  s  t1 t100 sn sp   st bz sl sc
        // Reset, then ring one cycle after the time reaches 07:30:00.
        add(1, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 30,  0, 0, 0, 0, 0,  1, 1, 0, 0);
        // Buzzer toggles every two 100 Hz strobes.
        add(0, 1, 30,  0, 0, 1, 0, 0,  1, 1, 0, 0);
        add(0, 1, 30,  0, 0, 1, 0, 0,  1, 0, 0, 0);
        add(0, 1, 30,  0, 0, 1, 0, 0,  1, 0, 0, 0);
        add(0, 1, 30,  0, 0, 1, 0, 0,  1, 1, 0, 0);
        // Timeout after three seconds, with 100 Hz strobes in the same cycles.
        add(0, 1, 30,  0, 1, 1, 0, 0,  1, 1, 0, 0);
        add(0, 1, 30,  0, 1, 1, 0, 0,  1, 0, 0, 0);
        add(0, 1, 30,  0, 1, 0, 0, 0,  0, 0, 0, 0);
        // Time still inside the match second: no re-ring.
        add(0, 1, 30,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 30,  1, 0, 0, 0, 0,  0, 0, 0, 0);
        // New alarm event, snooze, countdown, return to ring.
        add(0, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 30,  0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 1, 30,  1, 0, 0, 1, 0,  2, 0, 5, 1);
        add(0, 1, 30,  1, 0, 0, 1, 0,  2, 0, 5, 1);
        add(0, 1, 30,  1, 1, 0, 0, 0,  2, 0, 4, 1);
        add(0, 1, 30,  1, 1, 0, 0, 0,  2, 0, 3, 1);
        add(0, 1, 30,  1, 1, 0, 0, 0,  2, 0, 2, 1);
        add(0, 1, 30,  1, 1, 0, 0, 0,  2, 0, 1, 1);
        add(0, 1, 30,  1, 1, 0, 0, 0,  1, 1, 0, 1);
        // Snooze limit reached: ignored, ring continues; stop keeps the count.
        add(0, 1, 30,  1, 0, 0, 1, 0,  1, 1, 0, 1);
        add(0, 1, 30,  1, 1, 0, 0, 0,  1, 1, 0, 1);
        add(0, 1, 30,  1, 0, 0, 0, 1,  0, 0, 0, 1);

        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k]);
        end

        // Snooze and stop together: stop wins.
        run(0, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 1);
        run(0, 1, 30,  0, 0, 0, 0, 0,  1, 1, 0, 0);
        run(0, 1, 30,  1, 0, 0, 1, 1,  0, 0, 0, 0);
        // Snooze on the timeout tick: snooze wins.
        run(0, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        run(0, 1, 30,  0, 0, 0, 0, 0,  1, 1, 0, 0);
        run(0, 1, 30,  1, 1, 0, 0, 0,  1, 1, 0, 0);
        run(0, 1, 30,  1, 1, 0, 0, 0,  1, 1, 0, 0);
        run(0, 1, 30,  1, 1, 0, 1, 0,  2, 0, 5, 1);
        // Dropping alarm_en mid-snooze clears everything.
        run(0, 1, 30,  1, 1, 0, 0, 0,  2, 0, 4, 1);
        run(0, 1, 30,  1, 1, 0, 0, 0,  2, 0, 3, 1);
        run(0, 0, 30,  1, 0, 0, 0, 0,  0, 0, 0, 0);
        // Reset mid-ring, reset held over a match, fresh match after release.
        run(0, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        run(0, 1, 30,  0, 0, 0, 0, 0,  1, 1, 0, 0);
        run(0, 1, 30,  1, 0, 1, 0, 0,  1, 1, 0, 0);
        run(1, 1, 30,  1, 0, 0, 0, 0,  0, 0, 0, 0);
        run(1, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        run(1, 1, 30,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        run(0, 1, 30,  1, 0, 0, 0, 0,  0, 0, 0, 0);
        run(0, 1, 29, 59, 0, 0, 0, 0,  0, 0, 0, 0);
        run(0, 1, 30,  0, 0, 0, 0, 0,  1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
